// File: rtl/wb_port_arbiter_pkg.sv
// Shared constants and helpers for the regfile write-port arbiter.
// Mirrors the register-file widths and enable levels used across the core.
package wb_port_arbiter_pkg;

    localparam int REG_NUM_LOG2 = 5;
    localparam int REG_ADDR_W   = REG_NUM_LOG2;
    localparam int REG_W        = 32;

    localparam logic                  RST_ENABLE   = 1'b1;
    localparam logic                  WRITE_ENABLE = 1'b1;
    localparam logic [REG_W-1:0]      ZERO_WORD    = '0;
    localparam logic [REG_ADDR_W-1:0] ZERO_ADDR    = '0;

    localparam logic [3:0] STARVE_LIMIT_DEFAULT = 4'd4;

    typedef enum logic [1:0] {
        GRANT_NONE,
        GRANT_REQ0,
        GRANT_REQ1
    } grant_e;

    // Writes to r0 are architecturally discarded, so they never compete for the port.
    function automatic logic req_valid(input logic we, input logic [REG_ADDR_W-1:0] addr);
        return (we == WRITE_ENABLE) && (addr != ZERO_ADDR);
    endfunction

endpackage

// File: rtl/wb_port_arbiter.sv
// Arbitrates the single regfile write port between the pipeline (fixed priority)
// and the multi-cycle unit, with a starvation counter forcing unit grants.
module wb_port_arbiter
    import wb_port_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = int'(STARVE_LIMIT_DEFAULT),
    parameter int CNT_W        = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we0_i,
    input  logic [REG_ADDR_W-1:0] wd0_i,
    input  logic [REG_W-1:0]      wdata0_i,
    output logic                  ready0_o,
    input  logic                  we1_i,
    input  logic [REG_ADDR_W-1:0] wd1_i,
    input  logic [REG_W-1:0]      wdata1_i,
    output logic                  ready1_o,
    output logic                  drop1_o,
    output logic                  stallreq_o,
    output logic                  we_o,
    output logic [REG_ADDR_W-1:0] waddr_o,
    output logic [REG_W-1:0]      wdata_o
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    logic             valid0;
    logic             valid1;
    logic             active;
    grant_e           grant;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             force_q;
    logic             force_d;

    assign valid0 = req_valid(we0_i, wd0_i);
    assign valid1 = req_valid(we1_i, wd1_i);
    assign active = (rst != RST_ENABLE);

    // Priority: WAW squash, forced unit grant, pipeline, unit alone.
    always_comb begin
        grant    = GRANT_NONE;
        ready0_o = 1'b0;
        ready1_o = 1'b0;
        drop1_o  = 1'b0;
        cnt_d    = cnt_q;
        force_d  = force_q;

        if (active) begin
            if (we0_i && (wd0_i == ZERO_ADDR)) begin
                ready0_o = 1'b1;
            end
            if (we1_i && (wd1_i == ZERO_ADDR)) begin
                ready1_o = 1'b1;
            end

            if (valid0 && valid1 && (wd0_i == wd1_i)) begin
                grant    = GRANT_REQ0;
                ready0_o = 1'b1;
                ready1_o = 1'b1;
                drop1_o  = 1'b1;
                cnt_d    = '0;
                force_d  = 1'b0;
            end else if (force_q && valid1) begin
                grant    = GRANT_REQ1;
                ready1_o = 1'b1;
                cnt_d    = '0;
                force_d  = 1'b0;
            end else if (valid0) begin
                grant    = GRANT_REQ0;
                ready0_o = 1'b1;
                if (valid1 && (cnt_q < LIMIT)) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_d == LIMIT) begin
                        force_d = 1'b1;
                    end
                end
            end else if (valid1) begin
                grant    = GRANT_REQ1;
                ready1_o = 1'b1;
                cnt_d    = '0;
                force_d  = 1'b0;
            end

            if (!we1_i) begin
                cnt_d   = '0;
                force_d = 1'b0;
            end
        end
    end

    assign stallreq_o = active && valid0 && !ready0_o;

    // Registered write port: the accepted request lands in the regfile one cycle later.
    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            we_o    <= 1'b0;
            waddr_o <= ZERO_ADDR;
            wdata_o <= ZERO_WORD;
            cnt_q   <= '0;
            force_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            force_q <= force_d;
            case (grant)
                GRANT_REQ0: begin
                    we_o    <= 1'b1;
                    waddr_o <= wd0_i;
                    wdata_o <= wdata0_i;
                end
                GRANT_REQ1: begin
                    we_o    <= 1'b1;
                    waddr_o <= wd1_i;
                    wdata_o <= wdata1_i;
                end
                default: begin
                    we_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
Shares the single regfile write port between two producers.
- Requester 0: the in-order pipeline's MEM/WB result.
- Requester 1: the multi-cycle unit's result (divider/multiplier).
Fixed priority goes to the pipeline. A starvation counter forces a grant to the multi-cycle unit, stalling the pipeline through the existing stallreq path. Sits between the MEM/WB stage and the regfile; drives the regfile write port from registered outputs.

Parameters:
STARVE_LIMIT, 4, number of consecutive denied cycles requester 1 tolerates before forced grant (legal range 1..15)
CNT_W, 4, width of starvation counter; must hold STARVE_LIMIT

Ports:
clk  input  1  system clock
rst  input  1  reset; synchronous, active-high (`RstEnable = 1'b1)
we0_i  input  1  requester 0 (pipeline) write valid
wd0_i  input  `RegAddrBus  requester 0 destination register
wdata0_i  input  `RegBus  requester 0 data
ready0_o  output  1  requester 0 accepted this cycle
we1_i  input  1  requester 1 (multi-cycle unit) write valid; held with wd1_i/wdata1_i stable until ready1_o
wd1_i  input  `RegAddrBus  requester 1 destination register
wdata1_i  input  `RegBus  requester 1 data
ready1_o  output  1  requester 1 consumed (written or dropped) this cycle
drop1_o  output  1  requester 1 consumed without write (WAW squash)
stallreq_o  output  1  stall request to ctrl; asserted when requester 0 is valid and denied
we_o  output  1  regfile write enable (registered)
waddr_o  output  `RegAddrBus  regfile write address (registered)
wdata_o  output  `RegBus  regfile write data (registered)

Behaviour:
Reset:
- While rst=1: ready0_o, ready1_o, drop1_o and stallreq_o are all 0.
- At the first edge with rst=1: we_o, waddr_o, wdata_o, counter and force flag are all cleared.
- Reset mid-wait abandons any pending starvation count; requester 1 re-arbitrates from zero.

Zero address:
- A valid request with address 0 never uses the port. It gets ready=1 in the same cycle, independent of the other requester, and causes no write.
- Such a request does not advance or clear the counter.

Grant decision (combinational, evaluated each cycle; "valid" means we=1 with nonzero address):
1. Both valid, wd0_i == wd1_i: grant requester 0. ready1_o=1 and drop1_o=1, because the younger pipeline write supersedes. Counter and force flag clear.
2. Force flag set and requester 1 valid: grant requester 1. ready0_o=0; stallreq_o=1 if requester 0 is valid.
3. Requester 0 valid: grant requester 0. If requester 1 is valid, ready1_o=0 and the counter increments.
4. Requester 1 valid only: grant requester 1.
5. Neither valid: no grant; the next-cycle we_o=0.

Output registers:
- The granted request is loaded into we_o/waddr_o/wdata_o at the next edge, so the regfile write lands one cycle after acceptance.
- Latency from acceptance to regfile write is exactly 1 cycle; throughput is 1 write per cycle.
- When nothing is granted, we_o=0 and waddr_o/wdata_o hold their previous values.

Starvation counter:
- Resets to 0 on any requester-1 grant or drop, or when we1_i=0.
- When an increment makes the counter equal STARVE_LIMIT, the force flag sets at that edge.
- The force flag clears at the edge where requester 1 is granted or dropped, or where we1_i deasserts.
- The counter saturates at STARVE_LIMIT.
- Guarantee: requester 1 waits at most STARVE_LIMIT+1 cycles.

Stall:
- stallreq_o = we0_i & (wd0_i != 0) & ~ready0_o, combinational.
- ctrl must freeze MEM/WB so we0_i/wd0_i/wdata0_i are held the next cycle.

Decomposition:
- Reuse the constants already in defines.v: RegAddrBus, RegBus, RstEnable, WriteEnable, ZeroWord, RegNumLog2.
- Add `StarveLimit 4'd4 to defines.v as the default for STARVE_LIMIT.
- No sub-module: grant logic, counter and output register are implemented inline.

Test Plan:
- Requester 0 only, r5 <= 0x1234: ready0_o=1 in cycle N; we_o=1, waddr_o=5, wdata_o=0x1234 in cycle N+1; stallreq_o=0.
- Requester 1 only, r9 <= 0xDEAD: ready1_o=1 in the same cycle; we_o/waddr_o=9/wdata_o=0xDEAD the next cycle.
- Both valid, r3 (pipeline 0xAAAA) vs r3 (unit 0xBBBB): ready0_o=ready1_o=drop1_o=1; only 0xAAAA written to r3; counter stays 0.
- Starvation, STARVE_LIMIT=4, requester 0 valid to distinct nonzero addresses every cycle, requester 1 held on r7 <= 0x77:
  - ready1_o=0 for 4 cycles.
  - In the 5th cycle: ready1_o=1, ready0_o=0, stallreq_o=1.
  - Next edge: r7 <= 0x77 is written; the pipeline resumes the following cycle.
- Address-0 requests: requester 0 on r0 and requester 1 on r4 in the same cycle: both ready=1; only r4 is written; stallreq_o=0.
- Reset asserted in the cycle the counter reaches 3: outputs read 0 after the edge; after release requester 1 again waits a full 4 cycles before its forced grant.
